// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter sharing the bram port.
// Registered round-robin grant, cyc-locked bursts, stall watchdog.
module wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [SW-1:0] s_sel_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  output logic [1:0]    gnt_o
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO1 = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t        state;
  logic          last;
  logic [WW-1:0] wdog;
  logic          own0;
  logic          own1;
  logic          m_stb;
  logic          wdog_err;
  logic          stall;

  assign own0  = (state == GNT0);
  assign own1  = (state == GNT1);
  assign gnt_o = {own1, own0};

  always_comb begin
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cyc_o  = 1'b0;
    s_we_o   = 1'b0;
    m_stb    = 1'b0;
    if (own0) begin
      s_addr_o = m0_addr_i;
      s_dat_o  = m0_dat_i;
      s_sel_o  = m0_sel_i;
      s_cyc_o  = m0_cyc_i;
      s_we_o   = m0_we_i;
      m_stb    = m0_stb_i;
    end else if (own1) begin
      s_addr_o = m1_addr_i;
      s_dat_o  = m1_dat_i;
      s_sel_o  = m1_sel_i;
      s_cyc_o  = m1_cyc_i;
      s_we_o   = m1_we_i;
      m_stb    = m1_stb_i;
    end
  end

  // Expiry cycle: drop stb so the slave sees the cycle abandoned.
  assign wdog_err = m_stb && (wdog == TO1);
  assign s_stb_o  = m_stb && !wdog_err;
  assign stall    = s_stb_o && !s_ack_i && !s_err_i;

  assign m0_ack_o = own0 && s_ack_i;
  assign m0_err_o = own0 && (s_err_i || wdog_err);
  assign m0_dat_o = own0 ? s_dat_i : '0;
  assign m1_ack_o = own1 && s_ack_i;
  assign m1_err_o = own1 && (s_err_i || wdog_err);
  assign m1_dat_o = own1 ? s_dat_i : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
      wdog  <= '0;
    end else begin
      if (!stall)
        wdog <= '0;
      else if (wdog != TO1)
        wdog <= wdog + WW'(1);
      unique case (state)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last)) begin
            state <= GNT0;
            wdog  <= '0;
          end else if (m1_cyc_i) begin
            state <= GNT1;
            wdog  <= '0;
          end
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            last  <= 1'b0;
            wdog  <= '0;
            state <= m1_cyc_i ? GNT1 : IDLE;
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            last  <= 1'b1;
            wdog  <= '0;
            state <= m0_cyc_i ? GNT0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, reads, round-robin,
// burst lock, watchdog (TIMEOUT=8) and mid-burst reset.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_addr, m0_wdat, m0_rdat;
  logic [3:0]  m0_sel;
  logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic [31:0] m1_addr, m1_wdat, m1_rdat;
  logic [3:0]  m1_sel;
  logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [31:0] s_addr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic        s_cyc, s_stb, s_we, s_ack, s_err;
  logic [1:0]  gnt;

  int nvec = 0;
  int nerr = 0;
  int owner;

  wb_arbiter #(
    .AW(32), .DW(32), .SW(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
    .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_addr_i(m1_addr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_addr_o(s_addr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input logic v);
    if (k == 0) begin
      m0_cyc = v;
      m0_stb = v;
    end else begin
      m1_cyc = v;
      m1_stb = v;
    end
  endtask

  initial begin
    rst = 1'b0;
    m0_addr = '0; m0_wdat = '0; m0_sel = 4'hf; m0_we = 1'b0;
    m1_addr = 32'h0000_0200; m1_wdat = 32'h1234_5678;
    m1_sel = 4'h3; m1_we = 1'b1;
    s_rdat = '0; s_ack = 1'b1; s_err = 1'b0;
    req(0, 1'b1);
    req(1, 1'b1);

    // 1: reset with both requesting
    #12;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_scyc", 64'(s_cyc), 64'h0);
    chk("rst_sstb", 64'(s_stb), 64'h0);
    chk("rst_m0ack", 64'(m0_ack), 64'h0);
    chk("rst_m1ack", 64'(m1_ack), 64'h0);
    s_ack = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();
    chk("first_gnt", 64'(gnt), 64'h1);
    chk("first_scyc", 64'(s_cyc), 64'h1);
    @(negedge clk);
    req(0, 1'b0);
    req(1, 1'b0);
    tick();
    chk("idle_gnt", 64'(gnt), 64'h0);

    // 2: single M0 read
    @(negedge clk);
    m0_addr = 32'h0000_0010;
    req(0, 1'b1);
    #1;
    chk("rd_lat_scyc", 64'(s_cyc), 64'h0);
    tick();
    chk("rd_gnt", 64'(gnt), 64'h1);
    chk("rd_saddr", 64'(s_addr), 64'h10);
    chk("rd_sstb", 64'(s_stb), 64'h1);
    chk("rd_swe", 64'(s_we), 64'h0);
    @(negedge clk);
    s_ack = 1'b1;
    s_rdat = 32'hcafe_babe;
    #1;
    chk("rd_m0ack", 64'(m0_ack), 64'h1);
    chk("rd_m0dat", 64'(m0_rdat), 64'hcafe_babe);
    chk("rd_m1ack", 64'(m1_ack), 64'h0);
    chk("rd_m1dat", 64'(m1_rdat), 64'h0);
    @(negedge clk);
    s_ack = 1'b0;
    req(0, 1'b0);
    tick();
    chk("rd_end_gnt", 64'(gnt), 64'h0);

    // 3: both request 1-beat cycles; M0 went last, so M1 first
    @(negedge clk);
    req(0, 1'b1);
    req(1, 1'b1);
    tick();
    chk("rr_gnt0", 64'(gnt), 64'h2);
    owner = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_ack = 1'b1;
      #1;
      chk("rr_own_ack", 64'(owner == 0 ? m0_ack : m1_ack), 64'h1);
      chk("rr_oth_ack", 64'(owner == 0 ? m1_ack : m0_ack), 64'h0);
      @(negedge clk);
      s_ack = 1'b0;
      req(owner, 1'b0);
      tick();
      chk("rr_handover", 64'(gnt), owner == 0 ? 64'h2 : 64'h1);
      req(owner, 1'b1);
      owner = 1 - owner;
    end
    @(negedge clk);
    req(0, 1'b0);
    req(1, 1'b0);
    tick();
    chk("rr_end_gnt", 64'(gnt), 64'h0);

    // 4: M1 4-beat burst while M0 waits
    @(negedge clk);
    req(1, 1'b1);
    tick();
    chk("bst_gnt", 64'(gnt), 64'h2);
    @(negedge clk);
    req(0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      s_ack = 1'b1;
      s_rdat = 32'(b + 100);
      #1;
      chk("bst_lock", 64'(gnt), 64'h2);
      chk("bst_m1ack", 64'(m1_ack), 64'h1);
      chk("bst_m1dat", 64'(m1_rdat), 64'(b + 100));
      chk("bst_m0ack", 64'(m0_ack), 64'h0);
      @(negedge clk);
      s_ack = 1'b0;
    end
    @(negedge clk);
    req(1, 1'b0);
    #1;
    chk("bst_hold", 64'(gnt), 64'h2);
    tick();
    chk("bst_next", 64'(gnt), 64'h1);
    @(negedge clk);
    req(0, 1'b0);
    tick();
    chk("bst_end_gnt", 64'(gnt), 64'h0);

    // 5: watchdog on a slave that never answers M0
    @(negedge clk);
    req(0, 1'b1);
    tick();
    for (int k = 1; k <= 8; k++) begin
      chk("wd_m0err", 64'(m0_err), k == 8 ? 64'h1 : 64'h0);
      chk("wd_sstb", 64'(s_stb), k == 8 ? 64'h0 : 64'h1);
      chk("wd_m1err", 64'(m1_err), 64'h0);
      chk("wd_m1ack", 64'(m1_ack), 64'h0);
      tick();
    end
    chk("wd_restart_stb", 64'(s_stb), 64'h1);
    chk("wd_restart_err", 64'(m0_err), 64'h0);
    @(negedge clk);
    req(0, 1'b0);
    tick();
    chk("wd_end_gnt", 64'(gnt), 64'h0);

    // 6: asynchronous reset during an M1 burst
    @(negedge clk);
    req(1, 1'b1);
    tick();
    chk("ar_gnt", 64'(gnt), 64'h2);
    @(negedge clk);
    s_ack = 1'b1;
    @(negedge clk);
    s_ack = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_scyc", 64'(s_cyc), 64'h0);
    chk("ar_gnt0", 64'(gnt), 64'h0);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("ar_regnt", 64'(gnt), 64'h2);
    chk("ar_rescyc", 64'(s_cyc), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
